// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
//   req    : fetch request valid (master -> slave)
//   addr   : word-aligned fetch address (master -> slave)
//   gnt    : request accepted this cycle (slave -> master)
//   rvalid : read data valid, at most one per accepted request (slave -> master)
//   rdata  : read data (slave -> master)
interface if_fetch_unit_if;
  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, output addr, input gnt, input rvalid, input rdata);
  modport slave  (input req, input addr, output gnt, output rvalid, output rdata);
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage feeding the IF/ID pipeline register.
// Owns the PC, keeps one imem request outstanding at a time, buffers one
// returned instruction and stalls IF/ID until that buffer is valid.
// Ports:
//   clk, reset     clock (rising edge), asynchronous active-high reset
//   freeze         hazard freeze; holds the buffered instruction
//   branch_taken   redirect from EXE
//   branch_addr    redirect target, bits [1:0] ignored
//   imem           instruction-memory bus (master side)
//   pc_out         pc+4 of the buffered instruction
//   instruction    buffered instruction
//   if_stall       1 while no valid instruction is buffered
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_FETCH | request driven at pc, waiting for gnt
// S_WAIT  | request accepted, waiting for its response
// S_DRAIN | accepted request was made stale by a branch; drop its response
// S_HOLD  | instruction buffered and presented to IF/ID
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   freeze,
  input  logic                   branch_taken,
  input  logic [31:0]            branch_addr,
  if_fetch_unit_if.master        imem,
  output logic [31:0]            pc_out,
  output logic [31:0]            instruction,
  output logic                   if_stall
);

  typedef enum logic [1:0] {S_FETCH, S_WAIT, S_DRAIN, S_HOLD} state_t;

  state_t      state, next_state;
  logic [31:0] pc, next_pc;
  logic [31:0] instr_buf, next_instr_buf;
  logic [31:0] branch_target;

  assign branch_target = {branch_addr[31:2], 2'b00};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_FETCH;
      pc        <= RESET_PC;
      instr_buf <= 32'h0;
    end else begin
      state     <= next_state;
      pc        <= next_pc;
      instr_buf <= next_instr_buf;
    end
  end

  always_comb begin
    next_state     = state;
    next_pc        = pc;
    next_instr_buf = instr_buf;
    case (state)
      S_FETCH: begin
        // A grant coinciding with a redirect still owes a response, which
        // belongs to the old address and must be drained.
        if (branch_taken) begin
          next_pc    = branch_target;
          next_state = imem.gnt ? S_DRAIN : S_FETCH;
        end else if (imem.gnt) begin
          next_state = S_WAIT;
        end
      end
      S_WAIT: begin
        if (branch_taken) begin
          next_pc    = branch_target;
          next_state = imem.rvalid ? S_FETCH : S_DRAIN;
        end else if (imem.rvalid) begin
          next_instr_buf = imem.rdata;
          next_state     = S_HOLD;
        end
      end
      S_DRAIN: begin
        if (branch_taken) begin
          next_pc = branch_target;
        end
        if (imem.rvalid) begin
          next_state = S_FETCH;
        end
      end
      S_HOLD: begin
        if (branch_taken) begin
          next_pc    = branch_target;
          next_state = S_FETCH;
        end else if (!freeze) begin
          // IF/ID captures the buffered instruction on this edge.
          next_pc    = pc + 32'd4;
          next_state = S_FETCH;
        end
      end
      default: begin
        next_state = S_FETCH;
      end
    endcase
  end

  assign imem.req    = (state == S_FETCH) && !reset;
  assign imem.addr   = {pc[31:2], 2'b00};
  assign pc_out      = pc + 32'd4;
  assign instruction = instr_buf;
  assign if_stall    = (state != S_HOLD);

endmodule
